// File: rtl/color_pattern_sequencer.sv
// color_pattern_sequencer
//   Plays a stored sequence of 8-bit color vectors (4 slots x 2-bit color
//   index) into color_decoder. Each step is shown for ON_TICKS dwell ticks
//   and then blanked for OFF_TICKS ticks. The palette (color_shift) is
//   latched once per playback.
//
// Optional feature: define LOOP_EN to add the 'loop' input. With loop=1 at
//   the end of the last gap, playback restarts at step 0 with no done pulse.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en/addr/data   pattern memory write (accepted only while idle)
//   seq_len           steps to play, clamped to DEPTH (sampled on start)
//   palette_sel       palette for this playback (sampled on start)
//   start, abort      begin playback (level, idle only) / stop immediately
//   loop              (LOOP_EN only) repeat the pattern
//   busy              high in every state except IDLE
//   color_vec         color vector to color_decoder
//   color_shift       palette select to color_decoder
//   blank             display dark (IDLE, GAP, DONE)
//   step_idx          current step index
//   done              one-cycle pulse on normal completion
//
// state | meaning
// IDLE  | waiting for start, memory writable
// SHOW  | current step displayed for ON_TICKS ticks
// GAP   | display blanked for OFF_TICKS ticks
// DONE  | one-cycle completion pulse, then IDLE
module color_pattern_sequencer #(
    parameter int DEPTH     = 16,
    parameter int TICK_DIV  = 100000,
    parameter int ON_TICKS  = 50,
    parameter int OFF_TICKS = 25,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW:0]   seq_len,
    input  logic          palette_sel,
    input  logic          start,
    input  logic          abort,
`ifdef LOOP_EN
    input  logic          loop,
`endif
    output logic          busy,
    output logic [7:0]    color_vec,
    output logic          color_shift,
    output logic          blank,
    output logic [AW-1:0] step_idx,
    output logic          done
);

    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAXT = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int DW   = $clog2(MAXT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] pre, pre_nxt;
    logic [DW-1:0] dwell, dwell_nxt;
    logic [AW:0]   len, len_nxt;
    logic [AW-1:0] step_nxt;
    logic [7:0]    cv_nxt;
    logic          cs_nxt;
    logic          tick;
    logic          last_step;
    logic [7:0]    mem [DEPTH];

    assign tick      = (pre == PW'(TICK_DIV - 1));
    assign last_step = ({1'b0, step_idx} == (len - 1'b1));

    // Writes are dropped while busy so a running playback cannot change.
    always_ff @(posedge clk) begin
        if (wr_en && state == IDLE) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        state_nxt = state;
        pre_nxt   = pre;
        dwell_nxt = dwell;
        len_nxt   = len;
        step_nxt  = step_idx;
        cv_nxt    = color_vec;
        cs_nxt    = color_shift;

        if (state != IDLE) begin
            pre_nxt = tick ? '0 : pre + 1'b1;
        end

        if (abort) begin
            state_nxt = IDLE;
            pre_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_nxt   = (seq_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : seq_len;
                        cs_nxt    = palette_sel;
                        step_nxt  = '0;
                        pre_nxt   = '0;
                        dwell_nxt = DW'(ON_TICKS - 1);
                        if (seq_len == '0) begin
                            state_nxt = DONE;
                        end else begin
                            state_nxt = SHOW;
                            // Forward a same-cycle write to slot 0.
                            cv_nxt = (wr_en && wr_addr == '0) ? wr_data : mem[0];
                        end
                    end
                end
                SHOW: begin
                    if (tick) begin
                        if (dwell == '0) begin
                            state_nxt = GAP;
                            dwell_nxt = DW'(OFF_TICKS - 1);
                        end else begin
                            dwell_nxt = dwell - 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (dwell == '0) begin
                            dwell_nxt = DW'(ON_TICKS - 1);
                            if (last_step) begin
`ifdef LOOP_EN
                                if (loop) begin
                                    state_nxt = SHOW;
                                    step_nxt  = '0;
                                    cv_nxt    = mem[0];
                                end else begin
                                    state_nxt = DONE;
                                end
`else
                                state_nxt = DONE;
`endif
                            end else begin
                                state_nxt = SHOW;
                                step_nxt  = step_idx + 1'b1;
                                cv_nxt    = mem[step_idx + 1'b1];
                            end
                        end else begin
                            dwell_nxt = dwell - 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pre         <= '0;
            dwell       <= '0;
            len         <= '0;
            step_idx    <= '0;
            color_vec   <= '0;
            color_shift <= 1'b0;
            busy        <= 1'b0;
            blank       <= 1'b1;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            pre         <= pre_nxt;
            dwell       <= dwell_nxt;
            len         <= len_nxt;
            step_idx    <= step_nxt;
            color_vec   <= cv_nxt;
            color_shift <= cs_nxt;
            busy        <= (state_nxt != IDLE);
            blank       <= (state_nxt != SHOW);
            done        <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_color_pattern_sequencer.sv
// Bench for color_pattern_sequencer with DEPTH=4, TICK_DIV=4, ON_TICKS=2,
// OFF_TICKS=1 (SHOW = 8 clk, GAP = 4 clk). Expected per-cycle output words
// {busy, blank, done, color_shift, step_idx, color_vec} are queued as
// stimulus is planned and popped at each falling edge.
module tb_color_pattern_sequencer;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic [AW:0]   seq_len = '0;
    logic          palette_sel = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
`ifdef LOOP_EN
    logic          loop = 1'b0;
`endif
    logic          busy;
    logic [7:0]    color_vec;
    logic          color_shift;
    logic          blank;
    logic [AW-1:0] step_idx;
    logic          done;

    color_pattern_sequencer #(
        .DEPTH(DEPTH), .TICK_DIV(4), .ON_TICKS(2), .OFF_TICKS(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .seq_len(seq_len), .palette_sel(palette_sel),
        .start(start), .abort(abort),
`ifdef LOOP_EN
        .loop(loop),
`endif
        .busy(busy), .color_vec(color_vec), .color_shift(color_shift),
        .blank(blank), .step_idx(step_idx), .done(done)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    string       tag = "reset";
    logic [13:0] sb [$];
    logic [7:0]  mem_m [DEPTH];
    logic        m_cs = 1'b0;
    logic [AW-1:0] m_step = '0;
    logic [7:0]  m_cv = '0;

    task automatic push(input logic b_busy, input logic b_blank, input logic b_done);
        sb.push_back({b_busy, b_blank, b_done, m_cs, m_step, m_cv});
    endtask

    task automatic push_step(input int i);
        m_step = AW'(i);
        m_cv   = mem_m[i];
        repeat (8) push(1'b1, 1'b0, 1'b0);
        repeat (4) push(1'b1, 1'b1, 1'b0);
    endtask

    task automatic model_play(input int n, input logic pal);
        int len_c;
        len_c  = (n > DEPTH) ? DEPTH : n;
        m_cs   = pal;
        m_step = '0;
        for (int i = 0; i < len_c; i++) push_step(i);
        push(1'b1, 1'b1, 1'b1);
        push(1'b0, 1'b1, 1'b0);
    endtask

    task automatic compare_now();
        logic [13:0] exp_w;
        logic [13:0] obs_w;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty, observed output has no expectation", tag);
        end else begin
            exp_w = sb.pop_front();
            obs_w = {busy, blank, done, color_shift, step_idx, color_vec};
            assert (obs_w === exp_w) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h (busy,blank,done,cs,step,vec)",
                       tag, obs_w, exp_w);
            end
        end
    endtask

    task automatic check_cycle();
        @(negedge clk);
        compare_now();
    endtask

    task automatic drain();
        while (sb.size() > 0) check_cycle();
    endtask

    task automatic kick();
        start = 1'b1;
        check_cycle();
        start = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        push(1'b0, 1'b1, 1'b0);
        check_cycle();
        wr_en    = 1'b0;
        mem_m[a] = d;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        push(1'b0, 1'b1, 1'b0);
        compare_now();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic two-step playback on palette 1
        tag = "t1_load";
        wr(2'd0, 8'hE4);
        wr(2'd1, 8'h1B);
        tag = "t1_play";
        seq_len = 3'd2; palette_sel = 1'b1;
        model_play(2, 1'b1);
        kick();
        drain();

        // Zero length goes straight to DONE
        tag = "t2_len0";
        seq_len = 3'd0; palette_sel = 1'b0;
        model_play(0, 1'b0);
        kick();
        drain();

        // Over-long length clamps to DEPTH
        tag = "t2_load";
        wr(2'd2, 8'h5A);
        wr(2'd3, 8'hC3);
        tag = "t2_clamp";
        seq_len = 3'd7; palette_sel = 1'b1;
        model_play(7, 1'b1);
        kick();
        drain();

        // abort and start together in IDLE: nothing happens
        tag = "t3_abort_start";
        seq_len = 3'd2; palette_sel = 1'b0;
        start = 1'b1; abort = 1'b1;
        push(1'b0, 1'b1, 1'b0);
        check_cycle();
        start = 1'b0; abort = 1'b0;
        push(1'b0, 1'b1, 1'b0);
        check_cycle();

        // abort on the 3rd SHOW cycle of step 1
        tag = "t3_abort";
        m_cs = 1'b0;
        m_step = '0;
        push_step(0);
        m_step = 2'd1; m_cv = mem_m[1];
        repeat (3) push(1'b1, 1'b0, 1'b0);
        kick();
        repeat (14) check_cycle();
        abort = 1'b1;
        push(1'b0, 1'b1, 1'b0);
        check_cycle();
        abort = 1'b0;
        repeat (3) push(1'b0, 1'b1, 1'b0);
        drain();

        // start and writes during playback are ignored
        tag = "t4_ignore";
        seq_len = 3'd1; palette_sel = 1'b0;
        model_play(1, 1'b0);
        kick();
        repeat (2) check_cycle();
        start = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'hFF;
        repeat (8) check_cycle();
        start = 1'b0; wr_en = 1'b0;
        drain();
        tag = "t4_replay";
        model_play(1, 1'b0);
        kick();
        drain();

        // write in IDLE with start in the same cycle shows the new data
        tag = "t4_fwd";
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h99;
        mem_m[0] = 8'h99;
        seq_len = 3'd1; palette_sel = 1'b1;
        model_play(1, 1'b1);
        kick();
        wr_en = 1'b0;
        drain();

        // asynchronous reset in the middle of a GAP
        tag = "t5_run";
        seq_len = 3'd1; palette_sel = 1'b1;
        m_cs = 1'b1; m_step = '0; m_cv = mem_m[0];
        repeat (8) push(1'b1, 1'b0, 1'b0);
        repeat (2) push(1'b1, 1'b1, 1'b0);
        kick();
        drain();
        tag = "t5_reset";
        #2 rst_n = 1'b0;
        #1;
        m_cs = 1'b0; m_step = '0; m_cv = '0;
        push(1'b0, 1'b1, 1'b0);
        compare_now();
        @(negedge clk);
        rst_n = 1'b1;
        tag = "t5_after";
        repeat (3) push(1'b0, 1'b1, 1'b0);
        drain();
        tag = "t5_replay";
        model_play(1, 1'b1);
        kick();
        drain();

`ifdef LOOP_EN
        // loop repeats the single step until loop drops
        tag = "t6_loop";
        seq_len = 3'd1; palette_sel = 1'b0; loop = 1'b1;
        m_cs = 1'b0;
        repeat (3) push_step(0);
        push(1'b1, 1'b1, 1'b1);
        push(1'b0, 1'b1, 1'b0);
        kick();
        repeat (31) check_cycle();
        loop = 1'b0;
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
